mem_write_button: RTL and testbench
===================================

// Module: mem_write_button
// PURPOSE
//  Conditions the raw "commit write" pushbutton on the FPGA board and drives the
//  data memory's writeEnable input. Each debounced press produces exactly one
//  single-cycle writeEnable pulse. Tracks whether the memory is armed and waiting
//  for memWrite, and shows that on an LED. Sits between the board key pins and
//  the data memory, alongside the debug peek logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  cycles the key must be stable to be accepted (10 ms @ 50 MHz); must be >= 2
//  CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  KEY_ACTIVE_LOW   1       1: keyIn reads 0 when pressed (board keys); 0: reads 1 when pressed
//  COUNT_W          16      width of pressCount
// PORTS
//  Clk          in   1        system clock; all state updates on the rising edge
//  Rst          in   1        reset, asynchronous, active-low
//  keyIn        in   1        raw, asynchronous, bouncing pushbutton
//  memWrite     in   1        processor control signal; high when a store is presented to memory
//  writeEnable  out  1        one-cycle pulse per accepted press, to data memory writeEnable
//  keyLevel     out  1        debounced key level, 1 = pressed (polarity normalised)
//  armed        out  1        1 from the pulse until memory consumes a write (LED)
//  pressCount   out  COUNT_W  accepted presses, modulo 2**COUNT_W
// BEHAVIOUR
//  - Reset (Rst=0, acts immediately, no clock needed):
//    all outputs 0; state RELEASED; counter 0; both sync flops hold the released level.
//  - keyIn passes through a 2-flop synchroniser and is normalised to pressed=1 ("ks").
//  - FSM, one transition per edge:
//    RELEASED:     ks=1 -> PRESS_WAIT, cnt<=0
//    PRESS_WAIT:   ks=0 -> RELEASED (bounce rejected, no pulse)
//                  cnt==DEBOUNCE_CYCLES-1 -> PRESSED, writeEnable<=1, pressCount<=pressCount+1
//                  otherwise cnt<=cnt+1
//    PRESSED:      ks=0 -> RELEASE_WAIT, cnt<=0; holding the key never re-pulses
//    RELEASE_WAIT: ks=1 -> PRESSED, no pulse and no count
//                  cnt==DEBOUNCE_CYCLES-1 -> RELEASED; otherwise cnt<=cnt+1
//  - keyLevel = 1 in PRESSED and RELEASE_WAIT, 0 otherwise. Registered; no combinational path from keyIn.
//  - writeEnable is registered. It is high for exactly the one cycle after the
//    PRESS_WAIT->PRESSED edge, then returns to 0.
//  - Latency: keyIn pressed and stable before edge k -> ks=1 after edge k+1 ->
//    PRESS_WAIT at k+2 -> writeEnable high after edge k+2+DEBOUNCE_CYCLES.
//  - armed:
//    set on the edge where writeEnable is driven high;
//    cleared on an edge where armed=1 and memWrite=1 (memory takes the write at that edge).
//    If set and clear happen on the same edge, set wins.
//  - pressCount wraps from all-ones to 0 silently.
//  - Reset mid-operation abandons any debounce in progress and drops armed.
//    A key held through reset release runs a full debounce and then pulses once.
// STRUCTURE
//  - Shared include mem_debug_defs.vh: FSM state encodings (2-bit localparams
//    RELEASED/PRESS_WAIT/PRESSED/RELEASE_WAIT) and the default DEBOUNCE_CYCLES.
//    The peek/display logic reuses the same file.
//  - One sub-module: sync_2ff (2-flop synchroniser, async active-low reset,
//    reset-value parameter). Debounce FSM, counter, armed and pressCount stay in this module.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1, COUNT_W=4)
//  1. Clean press: keyIn 1->0 before edge 10, held 30 cycles
//     -> writeEnable high only after edge 16; pressCount 0->1; keyLevel=1; no second pulse.
//  2. Press bounce: keyIn low 2 cycles / high 1, repeated 5x, then high
//     -> writeEnable never high; pressCount stays 0; keyLevel stays 0.
//  3. Release bounce: in PRESSED, keyIn high 2 cycles then low 10
//     -> no pulse. Then high 10 cycles and low again -> exactly one further pulse; pressCount=2.
//  4. Armed handshake: after a pulse armed=1; memWrite=0 for 5 cycles -> armed holds 1;
//     memWrite=1 for 1 cycle -> armed=0 after that edge. memWrite=1 while armed=0 -> no change.
//  5. Async reset: assert Rst=0 mid-cycle during PRESS_WAIT -> all outputs 0 before the next edge;
//     after release with key up -> no pulse.
//  6. Wrap: 16 clean presses -> pressCount returns to 4'h0; exactly 16 writeEnable pulses counted.

Source files
------------

// File: rtl/mem_write_button_pkg.sv
// rtl/mem_write_button_pkg.sv - shared key FSM encodings and defaults for the commit-write button
package mem_write_button_pkg;

  // Debounce FSM states, 2-bit encodings shared with the peek/display logic
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Level the raw key pin sits at when nobody is touching it
  function automatic logic key_idle_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

  // Normalise a raw key sample to pressed = 1
  function automatic logic key_normalise(input logic raw, input int active_low);
    return (active_low != 0) ? ~raw : raw;
  endfunction

endpackage

// File: rtl/mem_write_button_sync_2ff.sv
// rtl/mem_write_button_sync_2ff.sv - two-flop synchroniser with selectable reset level
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset parks both at the idle level so no edge is seen on release
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_write_button.sv
// rtl/mem_write_button.sv - debounced commit-write key producing one writeEnable pulse per press
module mem_write_button
  import mem_write_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int COUNT_W         = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               keyIn,
  input  logic               memWrite,
  output logic               writeEnable,
  output logic               keyLevel,
  output logic               armed,
  output logic [COUNT_W-1:0] pressCount
);

  localparam logic             KEY_IDLE = key_idle_level(KEY_ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               key_sync;
  logic               ks;
  key_state_e         state;
  key_state_e         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               we_nxt;
  logic               level_nxt;
  logic               armed_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               cnt_done;

  sync_2ff #(
    .RESET_VAL (KEY_IDLE)
  ) u_key_sync (
    .Clk (Clk),
    .Rst (Rst),
    .d   (keyIn),
    .q   (key_sync)
  );

  assign ks       = key_normalise(key_sync, KEY_ACTIVE_LOW);
  assign cnt_done = (cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= RELEASED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a key level must survive DEBOUNCE_CYCLES cycles before it is believed
  always_comb begin
    state_nxt = state;
    case (state)
      RELEASED: begin
        if (ks) begin
          state_nxt = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!ks) begin
          state_nxt = RELEASED;
        end else if (cnt_done) begin
          state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (!ks) begin
          state_nxt = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (ks) begin
          state_nxt = PRESSED;
        end else if (cnt_done) begin
          state_nxt = RELEASED;
        end
      end
      default: begin
        state_nxt = RELEASED;
      end
    endcase
  end

  // Output/datapath next values: counter, pulse, level, armed flag and press count
  always_comb begin
    cnt_nxt = cnt;
    we_nxt  = 1'b0;
    case (state)
      RELEASED: begin
        if (ks) begin
          cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (ks) begin
          if (cnt_done) begin
            we_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      PRESSED: begin
        if (!ks) begin
          cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!ks && !cnt_done) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase

    // Level follows the debounced view: a release still being verified counts as pressed
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

    // A new pulse re-arms even if memory consumes the previous write on the same edge
    if (we_nxt) begin
      armed_nxt = 1'b1;
    end else if (armed && memWrite) begin
      armed_nxt = 1'b0;
    end else begin
      armed_nxt = armed;
    end

    count_nxt = we_nxt ? (pressCount + COUNT_W'(1)) : pressCount;
  end

  // Registered outputs so nothing combinational reaches the memory or the LEDs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt         <= '0;
      writeEnable <= 1'b0;
      keyLevel    <= 1'b0;
      armed       <= 1'b0;
      pressCount  <= '0;
    end else begin
      cnt         <= cnt_nxt;
      writeEnable <= we_nxt;
      keyLevel    <= level_nxt;
      armed       <= armed_nxt;
      pressCount  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_mem_write_button.sv
// tb/tb_mem_write_button.sv - scoreboard bench for the commit-write button debouncer
module tb_mem_write_button;

  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  logic       Clk;
  logic       Rst;
  logic       keyIn;
  logic       memWrite;
  logic       writeEnable;
  logic       keyLevel;
  logic       armed;
  logic [3:0] pressCount;

  int         cyc;
  int         vectors;
  int         miscompares;
  int         pulses;
  int         exp_cnt;
  int         c;
  int         pulses_before;
  exp_t       sb[$];

  mem_write_button #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .KEY_ACTIVE_LOW  (1),
    .COUNT_W         (4)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .keyIn       (keyIn),
    .memWrite    (memWrite),
    .writeEnable (writeEnable),
    .keyLevel    (keyLevel),
    .armed       (armed),
    .pressCount  (pressCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Press issued at the current negedge: pulse lands D+3 edges later
  task automatic press_expect();
    c = cyc;
    keyIn = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    sb.push_back('{cyc: c + D + 3, cnt: 4'(exp_cnt)});
  endtask

  // Monitor: every writeEnable pulse must match the head of the scoreboard
  always @(negedge Clk) begin
    if (Rst && writeEnable) begin
      pulses = pulses + 1;
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_count", int'(pressCount), int'(e.cnt));
        check("pulse_level", int'(keyLevel), 1);
      end
    end
  end

  initial begin
    cyc = 0; vectors = 0; miscompares = 0; pulses = 0; exp_cnt = 0;
    Rst = 1'b0; keyIn = 1'b1; memWrite = 1'b0;
    tick(2);
    check("rst_we", int'(writeEnable), 0);
    check("rst_level", int'(keyLevel), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_count", int'(pressCount), 0);
    Rst = 1'b1;

    // 1. clean press, low before edge 10 -> pulse after edge 16
    while (cyc != 9) @(negedge Clk);
    keyIn = 1'b0;
    exp_cnt = 1;
    sb.push_back('{cyc: 16, cnt: 4'd1});
    tick(30);
    check("t1_level", int'(keyLevel), 1);
    check("t1_count", int'(pressCount), 1);
    check("t1_armed", int'(armed), 1);
    keyIn = 1'b1;
    tick(10);
    check("t1_released", int'(keyLevel), 0);

    // 4. armed handshake
    tick(5);
    check("t4_hold", int'(armed), 1);
    memWrite = 1'b1;
    tick(1);
    memWrite = 1'b0;
    check("t4_clear", int'(armed), 0);
    memWrite = 1'b1;
    tick(2);
    memWrite = 1'b0;
    check("t4_idle", int'(armed), 0);

    // 2. press bounce
    for (int i = 0; i < 5; i++) begin
      keyIn = 1'b0;
      tick(2);
      check("t2_level", int'(keyLevel), 0);
      keyIn = 1'b1;
      tick(1);
      check("t2_level", int'(keyLevel), 0);
    end
    tick(10);
    check("t2_count", int'(pressCount), 1);
    check("t2_level_end", int'(keyLevel), 0);

    // 3. release bounce then a real re-press
    press_expect();
    tick(12);
    keyIn = 1'b1;
    tick(2);
    keyIn = 1'b0;
    tick(10);
    check("t3_still_pressed", int'(keyLevel), 1);
    check("t3_count_mid", int'(pressCount), 2);
    keyIn = 1'b1;
    tick(10);
    check("t3_released", int'(keyLevel), 0);
    press_expect();
    tick(12);
    check("t3_count", int'(pressCount), 3);
    keyIn = 1'b1;
    tick(10);

    // 5. async reset mid-cycle during PRESS_WAIT
    check("t5_armed_before", int'(armed), 1);
    keyIn = 1'b0;
    tick(4);
    #2 Rst = 1'b0;
    #1;
    check("t5_we", int'(writeEnable), 0);
    check("t5_level", int'(keyLevel), 0);
    check("t5_armed", int'(armed), 0);
    check("t5_count", int'(pressCount), 0);
    keyIn = 1'b1;
    exp_cnt = 0;
    tick(2);
    Rst = 1'b1;
    tick(15);
    check("t5_no_pulse_count", int'(pressCount), 0);
    check("t5_no_pulse_armed", int'(armed), 0);

    // 5b. key held through reset release -> one pulse after a full debounce
    Rst = 1'b0;
    keyIn = 1'b0;
    tick(2);
    c = cyc;
    Rst = 1'b1;
    exp_cnt = 1;
    sb.push_back('{cyc: c + D + 3, cnt: 4'd1});
    tick(14);
    check("t5b_count", int'(pressCount), 1);
    check("t5b_level", int'(keyLevel), 1);
    keyIn = 1'b1;
    tick(10);

    // 6. wrap after 16 presses from zero
    Rst = 1'b0;
    tick(2);
    Rst = 1'b1;
    exp_cnt = 0;
    tick(2);
    pulses_before = pulses;
    for (int i = 0; i < 16; i++) begin
      press_expect();
      tick(10);
      keyIn = 1'b1;
      tick(10);
    end
    check("t6_wrap", int'(pressCount), 0);
    check("t6_pulses", pulses - pulses_before, 16);

    tick(5);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the flow above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
